regfile_wb_scheduler: RTL and testbench



---
 rtl/rv32_rf_pkg.sv | 24 ++
 rtl/regfile_wb_scheduler_rr_arbiter.sv | 36 +++
 rtl/regfile_wb_scheduler.sv | 152 +++++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_rf_pkg.sv
// rv32_rf_pkg
//   Shared sizing constants for the register-file write-back path, the
//   fixed requester numbering used by the execution units, and a helper
//   that sizes the round-robin pointer.
//   No ports (package).

package rv32_rf_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int ADDRESS_BIT_WIDTH = 5;
    localparam int NB_OF_REGS        = 32;
    localparam int NB_REQ            = 3;

    // Requester slot numbering on the write-back request bus.
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MUL = 2;

    // Width of a pointer that selects one of n requesters (at least 1 bit).
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter. Grants the first valid
//   requester found searching upward from ptr, wrapping at N.
//   Ports:
//     valid  in   N      request vector
//     ptr    in   PTR_W  highest-priority index this cycle (must be < N)
//     grant  out  N      one-hot grant, all-zero when no request

module rr_arbiter
    import rv32_rf_pkg::*;
#(
    parameter int N     = 3,
    parameter int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    logic [2*N-1:0] valid_dbl;
    logic [2*N-1:0] grant_dbl;
    logic [N-1:0]   valid_rot;
    logic [N-1:0]   grant_rot;

    // Rotate the request vector so ptr lands on bit 0, take the lowest set
    // bit, then rotate the one-hot result back. Doubling the vector turns
    // the wrap-around into a plain shift.
    always_comb begin
        valid_dbl = {valid, valid};
        valid_rot = N'(valid_dbl >> ptr);
        grant_rot = valid_rot & (~valid_rot + N'(1));
        grant_dbl = {grant_rot, grant_rot} << ptr;
        grant     = grant_dbl[2*N-1:N];
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//   Arbitrates write-back requests from several execution units onto the
//   single register-file write port and keeps a scoreboard of destination
//   registers that have issued but not yet been written back, raising a
//   decode stall on RAW/WAW hazards.
//   Ports:
//     clk, rstn           clock, asynchronous active-low reset
//     en                  block enable (freezes scoreboard and arbitration)
//     req_valid/addr/data write-back requests, requester i in slice i
//     req_ready           one-hot grant (combinational)
//     issue_valid/rd      instruction issuing this cycle with destination rd
//     rs1, rs2            source indices of the instruction in decode
//     hazard              decode stall (combinational)
//     rf_we/a3/wd3        registered register-file write port

module regfile_wb_scheduler
    import rv32_rf_pkg::*;
#(
    parameter int DATA_WIDTH        = rv32_rf_pkg::DATA_WIDTH,
    parameter int ADDRESS_BIT_WIDTH = rv32_rf_pkg::ADDRESS_BIT_WIDTH,
    parameter int NB_OF_REGS        = rv32_rf_pkg::NB_OF_REGS,
    parameter int NB_REQ            = rv32_rf_pkg::NB_REQ
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                en,
    input  logic [NB_REQ-1:0]                   req_valid,
    input  logic [NB_REQ*ADDRESS_BIT_WIDTH-1:0] req_addr,
    input  logic [NB_REQ*DATA_WIDTH-1:0]        req_data,
    output logic [NB_REQ-1:0]                   req_ready,
    input  logic                                issue_valid,
    input  logic [ADDRESS_BIT_WIDTH-1:0]        issue_rd,
    input  logic [ADDRESS_BIT_WIDTH-1:0]        rs1,
    input  logic [ADDRESS_BIT_WIDTH-1:0]        rs2,
    output logic                                hazard,
    output logic                                rf_we,
    output logic [ADDRESS_BIT_WIDTH-1:0]        rf_a3,
    output logic [DATA_WIDTH-1:0]               rf_wd3
);

    localparam int AW    = ADDRESS_BIT_WIDTH;
    localparam int DW    = DATA_WIDTH;
    localparam int PTR_W = ptr_width(NB_REQ);

    logic [PTR_W-1:0]      rr_ptr;
    logic [NB_REQ-1:0]     grant;
    logic                  handshake;
    logic [PTR_W-1:0]      sel_idx;
    logic [AW-1:0]         sel_addr;
    logic [DW-1:0]         sel_data;
    logic [NB_OF_REGS-1:0] pending;
    logic [NB_OF_REGS-1:0] pending_nxt;

    rr_arbiter #(
        .N     (NB_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Grant is suppressed outright in reset and when disabled, so no
    // handshake can form in either case.
    assign req_ready = (rstn && en) ? grant : '0;
    assign handshake = |(req_valid & req_ready);

    // Select the granted requester's index, address and data.
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise the tool infers a latch.
    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (req_ready[i]) begin
                sel_idx  = PTR_W'(i);
                sel_addr = req_addr[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
            end
        end
    end

    // Scoreboard update: clear on write-back first, then set on issue so a
    // same-edge issue to the register being written leaves it pending.
    // Entry 0 is never touched, keeping x0 permanently clear.
    always_comb begin
        pending_nxt = pending;
        if (en) begin
            for (int r = 1; r < NB_OF_REGS; r++) begin
                if (handshake && sel_addr == AW'(r)) begin
                    pending_nxt[r] = 1'b0;
                end
                if (issue_valid && issue_rd == AW'(r)) begin
                    pending_nxt[r] = 1'b1;
                end
            end
        end
    end

    // NOTE: the scoreboard is a flop vector, not a storage array, and must
    // be reset: a stale pending bit would stall decode indefinitely.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr  <= '0;
            pending <= '0;
            rf_we   <= 1'b0;
            rf_a3   <= '0;
            rf_wd3  <= '0;
        end else begin
            pending <= pending_nxt;
            // x0 writes consume the grant but never reach the register file.
            rf_we   <= handshake && (sel_addr != '0);
            if (handshake) begin
                rr_ptr <= (sel_idx == PTR_W'(NB_REQ - 1)) ? '0 : sel_idx + 1'b1;
            end
            if (handshake && (sel_addr != '0)) begin
                rf_a3  <= sel_addr;
                rf_wd3 <= sel_data;
            end
        end
    end

    function automatic logic is_pending(input logic [NB_OF_REGS-1:0] vec,
                                        input logic [AW-1:0]         idx);
        logic res;
        res = 1'b0;
        for (int r = 1; r < NB_OF_REGS; r++) begin
            if (idx == AW'(r)) begin
                res = vec[r];
            end
        end
        return res;
    endfunction

    // A source is hazardous while its producer is outstanding, and also in
    // the cycle its value sits on the write port, since the register file
    // only commits it at the following edge.
    logic src1_haz;
    logic src2_haz;
    logic waw_haz;

    always_comb begin
        src1_haz = (rs1 != '0) && (is_pending(pending, rs1) || (rf_we && rf_a3 == rs1));
        src2_haz = (rs2 != '0) && (is_pending(pending, rs2) || (rf_we && rf_a3 == rs2));
        waw_haz  = issue_valid && (issue_rd != '0) && is_pending(pending, issue_rd);
        hazard   = src1_haz || src2_haz || waw_haz;
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb_regfile_wb_scheduler
//   Directed self-checking bench for regfile_wb_scheduler: reset values,
//   round-robin order, write latency, x0 filtering, scoreboard hazards,
//   set/clear priority, enable freeze and mid-burst reset. A monitor flags
//   requesters that drop or change a request while it is stalled.

module tb_regfile_wb_scheduler;
    import rv32_rf_pkg::*;

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDRESS_BIT_WIDTH;
    localparam int NR = NB_REQ;

    logic              clk;
    logic              rstn;
    logic              en;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              issue_valid;
    logic [AW-1:0]     issue_rd;
    logic [AW-1:0]     rs1;
    logic [AW-1:0]     rs2;
    logic              hazard;
    logic              rf_we;
    logic [AW-1:0]     rf_a3;
    logic [DW-1:0]     rf_wd3;

    int checks = 0;
    int errors = 0;

    regfile_wb_scheduler dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard),
        .rf_we       (rf_we),
        .rf_a3       (rf_a3),
        .rf_wd3      (rf_wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // Requester protocol monitor: a request stalled at an enabled edge must
    // still be presented, unchanged, at the next edge.
    logic [NR-1:0]    held;
    logic [NR*AW-1:0] held_addr;
    logic [NR*DW-1:0] held_data;

    initial held = '0;

    always @(posedge clk) begin
        if (!rstn) begin
            held <= '0;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (held[i]) begin
                    checks++;
                    assert (req_valid[i] === 1'b1 &&
                            req_addr[i*AW +: AW] === held_addr[i*AW +: AW] &&
                            req_data[i*DW +: DW] === held_data[i*DW +: DW]) else begin
                        errors++;
                        $error("FAIL hold_stable req%0d observed v=%0b a=%0h expected v=1 a=%0h",
                               i, req_valid[i], req_addr[i*AW +: AW], held_addr[i*AW +: AW]);
                    end
                end
            end
            held      <= req_valid & ~req_ready & {NR{en}};
            held_addr <= req_addr;
            held_data <= req_data;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn        = 1'b0;
        en          = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;

        // Reset state, with all requesters already asking.
        tick();
        en = 1'b1;
        set_req(REQ_ALU, 5'd1, 32'h100);
        set_req(REQ_LSU, 5'd2, 32'h200);
        set_req(REQ_MUL, 5'd3, 32'h300);
        req_valid = 3'b111;
        #1;
        check("rst_ready",  req_ready, 3'b000);
        check("rst_we",     rf_we,     1'b0);
        check("rst_a3",     rf_a3,     5'd0);
        check("rst_wd3",    rf_wd3,    32'h0);
        check("rst_hazard", hazard,    1'b0);
        tick();

        // Round robin with all requesters valid continuously.
        rstn = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            check("rr_grant", req_ready, 3'b001 << (k % 3));
            tick();
            check("rr_we",  rf_we,  1'b1);
            check("rr_a3",  rf_a3,  5'(k % 3 + 1));
            check("rr_wd3", rf_wd3, 32'((k % 3 + 1) << 8));
        end
        check("rr_grant7", req_ready, 3'b001);
        tick();
        check("rr_we7", rf_we, 1'b1);

        // Reset pulsed mid-burst (rr_ptr is 1 at this point).
        rstn = 1'b0;
        #1;
        check("midrst_ready",  req_ready, 3'b000);
        check("midrst_we",     rf_we,     1'b0);
        check("midrst_a3",     rf_a3,     5'd0);
        check("midrst_wd3",    rf_wd3,    32'h0);
        check("midrst_hazard", hazard,    1'b0);
        tick();
        rstn = 1'b1;
        #1;
        check("midrst_ptr0", req_ready, 3'b001);
        req_valid = '0;

        // Write latency: LSU writes x5 = 0x2004 alone.
        set_req(REQ_LSU, 5'd5, 32'h2004);
        req_valid = 3'b010;
        #1;
        check("lat_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        #1;
        check("lat_we",  rf_we,  1'b1);
        check("lat_a3",  rf_a3,  5'd5);
        check("lat_wd3", rf_wd3, 32'h2004);
        tick();
        check("lat_we_off",  rf_we,  1'b0);
        check("lat_a3_hold", rf_a3,  5'd5);
        check("lat_wd3_hold", rf_wd3, 32'h2004);

        // x0 filtering: ALU writes x0 (rr_ptr is 2, search wraps to 0).
        set_req(REQ_ALU, 5'd0, 32'hFFFF_FFFF);
        req_valid = 3'b001;
        #1;
        check("x0_ready", req_ready, 3'b001);
        tick();
        check("x0_we", rf_we, 1'b0);
        req_valid = 3'b111;
        #1;
        check("x0_ptr1", req_ready, 3'b010);
        req_valid = '0;

        // Scoreboard: issue rd=9, then rs1=9 while LSU writes x9 = 10.
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        #1;
        check("sb_issue_haz", hazard, 1'b0);
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd9;
        #1;
        check("sb_raw_pend", hazard, 1'b1);
        set_req(REQ_LSU, 5'd9, 32'd10);
        req_valid = 3'b010;
        #1;
        check("sb_ready",    req_ready, 3'b010);
        check("sb_raw_hs",   hazard,    1'b1);
        tick();
        req_valid = '0;
        #1;
        check("sb_we",       rf_we,  1'b1);
        check("sb_a3",       rf_a3,  5'd9);
        check("sb_wd3",      rf_wd3, 32'd10);
        check("sb_raw_wport", hazard, 1'b1);
        tick();
        check("sb_we_off",   rf_we,  1'b0);
        check("sb_clear",    hazard, 1'b0);
        tick();
        check("sb_clear2",   hazard, 1'b0);
        rs1 = '0;

        // Same-edge set and clear of x7 (rr_ptr is 2).
        set_req(REQ_MUL, 5'd7, 32'h77);
        req_valid   = 3'b100;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        check("sc_ready", req_ready, 3'b100);
        check("sc_haz0",  hazard,    1'b0);
        tick();
        req_valid   = '0;
        issue_valid = 1'b0;
        rs2 = 5'd7;
        #1;
        check("sc_we",   rf_we,  1'b1);
        check("sc_rs2_haz", hazard, 1'b1);
        tick();
        check("sc_pending_kept", hazard, 1'b1);
        rs2 = '0;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        check("sc_waw", hazard, 1'b1);
        issue_valid = 1'b0;
        #1;
        check("sc_idle_haz", hazard, 1'b0);

        // Enable: rr_ptr is 0 here.
        set_req(REQ_ALU, 5'd4, 32'h44);
        req_valid = 3'b001;
        #1;
        check("en_ready", req_ready, 3'b001);
        tick();
        check("en_we", rf_we, 1'b1);
        en = 1'b0;
        #1;
        check("dis_ready", req_ready, 3'b000);
        tick();
        check("dis_we",    rf_we,     1'b0);
        check("dis_ready2", req_ready, 3'b000);
        rs1 = 5'd7;
        #1;
        check("dis_hazard", hazard, 1'b1);
        rs1 = '0;
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        tick();
        issue_valid = 1'b0;
        rs1 = 5'd12;
        #1;
        check("dis_pend_frozen", hazard, 1'b0);
        rs1 = '0;
        en = 1'b1;
        set_req(REQ_LSU, 5'd6, 32'h66);
        req_valid = 3'b011;
        #1;
        check("dis_ptr_frozen", req_ready, 3'b010);
        tick();
        req_valid = 3'b001;
        #1;
        check("ren_we",  rf_we,  1'b1);
        check("ren_a3",  rf_a3,  5'd6);
        check("ren_wd3", rf_wd3, 32'h66);
        check("ren_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        #1;
        check("b2b_we",  rf_we,  1'b1);
        check("b2b_a3",  rf_a3,  5'd4);
        check("b2b_wd3", rf_wd3, 32'h44);
        tick();
        check("end_we", rf_we, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
